// File: rtl/dram_dma_pkg.sv
// Shared definitions for the DRAM block-copy engine: FSM state encoding and
// the fixed byte-enable pattern for full 16-bit word accesses.
package dram_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } dma_state_t;

    localparam logic [1:0] DMA_BSEL_WORD = 2'b11;
    localparam int         DMA_DATA_W    = 16;

endpackage

// File: rtl/dma_fifo.sv
// Burst buffer for the DMA engine: small synchronous FIFO with flush.
// Exposes the head word and the word behind it so write data can be preloaded.
module dma_fifo
    import dram_dma_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  fclk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DMA_DATA_W-1:0] push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic                  empty,
    output logic                  full,
    output logic [DMA_DATA_W-1:0] head,
    output logic [DMA_DATA_W-1:0] head_next
);

    localparam int AW = $clog2(DEPTH);

    logic [DMA_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [AW:0]           count_reg;

    always_ff @(posedge fclk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign head      = mem[rd_ptr_reg];
    assign head_next = mem[rd_ptr_reg + AW'(1)];

endmodule

// File: rtl/dram_dma.sv
// DRAM->DRAM block-copy engine: reads bursts of up to FIFO_DEPTH words, then writes them out.
// Define DMA_FILL_EN to add cfg_fill/cfg_mode and a constant-fill mode that skips the read phase.
module dram_dma
    import dram_dma_pkg::*;
#(
    parameter int ADDR_W     = 21,
    parameter int LEN_W      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  fclk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     cfg_src,
    input  logic [ADDR_W-1:0]     cfg_dst,
    input  logic [LEN_W-1:0]      cfg_len,
`ifdef DMA_FILL_EN
    input  logic [DMA_DATA_W-1:0] cfg_fill,
    input  logic                  cfg_mode,
`endif
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  irq_n,
    input  logic                  irq_ack,
    output logic                  dma_req,
    output logic                  dma_rnw,
    output logic [ADDR_W-1:0]     dma_addr,
    output logic [DMA_DATA_W-1:0] dma_wrdata,
    output logic [1:0]            dma_bsel,
    input  logic                  dma_ack,
    input  logic [DMA_DATA_W-1:0] dma_rddata
);

    localparam int BW = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [BW-1:0] burst_of(input logic [LEN_W-1:0] n);
        if (n >= LEN_W'(FIFO_DEPTH)) return BW'(FIFO_DEPTH);
        return BW'(n);
    endfunction

    logic                  start_fill;
    logic [DMA_DATA_W-1:0] start_fill_word;
`ifdef DMA_FILL_EN
    assign start_fill      = cfg_mode;
    assign start_fill_word = cfg_fill;
`else
    assign start_fill      = 1'b0;
    assign start_fill_word = '0;
`endif

    dma_state_t            state_reg, state_next;
    logic [ADDR_W-1:0]     src_reg, src_next, dst_reg, dst_next;
    logic [LEN_W-1:0]      rem_reg, rem_next;
    logic [BW-1:0]         burst_reg, burst_next;
    logic                  abort_pend_reg, abort_pend_next;
    logic                  fill_mode_reg, fill_mode_next;
    logic [DMA_DATA_W-1:0] fill_word_reg, fill_word_next;
    logic                  busy_reg, busy_next, done_reg, done_next, irq_n_reg, irq_n_next;
    logic                  dma_req_reg, dma_req_next, dma_rnw_reg, dma_rnw_next;
    logic [ADDR_W-1:0]     dma_addr_reg, dma_addr_next;
    logic [DMA_DATA_W-1:0] dma_wrdata_reg, dma_wrdata_next;

    logic                  fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
    logic [DMA_DATA_W-1:0] fifo_head, fifo_head_next;
    logic                  stop, last_wr;

    dma_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .fclk      (fclk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (dma_rddata),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .head      (fifo_head),
        .head_next (fifo_head_next)
    );

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            src_reg        <= '0;
            dst_reg        <= '0;
            rem_reg        <= '0;
            burst_reg      <= '0;
            abort_pend_reg <= 1'b0;
            fill_mode_reg  <= 1'b0;
            fill_word_reg  <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            irq_n_reg      <= 1'b1;
            dma_req_reg    <= 1'b0;
            dma_rnw_reg    <= 1'b1;
            dma_addr_reg   <= '0;
            dma_wrdata_reg <= '0;
        end else begin
            state_reg      <= state_next;
            src_reg        <= src_next;
            dst_reg        <= dst_next;
            rem_reg        <= rem_next;
            burst_reg      <= burst_next;
            abort_pend_reg <= abort_pend_next;
            fill_mode_reg  <= fill_mode_next;
            fill_word_reg  <= fill_word_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            irq_n_reg      <= irq_n_next;
            dma_req_reg    <= dma_req_next;
            dma_rnw_reg    <= dma_rnw_next;
            dma_addr_reg   <= dma_addr_next;
            dma_wrdata_reg <= dma_wrdata_next;
        end
    end

    // In fill mode the burst counter is meaningless; the word count alone ends the transfer.
    assign last_wr = fill_mode_reg ? (rem_reg == LEN_W'(1)) : (burst_reg == BW'(1));

    always_comb begin
        state_next      = state_reg;
        src_next        = src_reg;
        dst_next        = dst_reg;
        rem_next        = rem_reg;
        burst_next      = burst_reg;
        abort_pend_next = abort_pend_reg;
        fill_mode_next  = fill_mode_reg;
        fill_word_next  = fill_word_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;
        irq_n_next      = irq_n_reg;
        dma_req_next    = dma_req_reg;
        dma_rnw_next    = dma_rnw_reg;
        dma_addr_next   = dma_addr_reg;
        dma_wrdata_next = dma_wrdata_reg;
        fifo_push       = 1'b0;
        fifo_pop        = 1'b0;
        fifo_flush      = 1'b0;
        stop            = 1'b0;

        if (irq_ack) irq_n_next = 1'b1;

        case (state_reg)
            ST_IDLE: begin
                if (start && cfg_len == '0) begin
                    done_next  = 1'b1;
                    irq_n_next = 1'b0;
                end else if (start) begin
                    src_next       = cfg_src;
                    dst_next       = cfg_dst;
                    rem_next       = cfg_len;
                    burst_next     = burst_of(cfg_len);
                    fill_mode_next = start_fill;
                    fill_word_next = start_fill_word;
                    busy_next      = 1'b1;
                    dma_req_next   = 1'b1;
                    if (start_fill) begin
                        state_next      = ST_WR;
                        dma_rnw_next    = 1'b0;
                        dma_addr_next   = cfg_dst;
                        dma_wrdata_next = start_fill_word;
                    end else begin
                        state_next    = ST_RD;
                        dma_rnw_next  = 1'b1;
                        dma_addr_next = cfg_src;
                    end
                end
            end
            ST_RD: begin
                if (dma_ack) begin
                    fifo_push = !fifo_full;
                    src_next  = src_reg + ADDR_W'(1);
                    if (abort || abort_pend_reg) begin
                        stop = 1'b1;
                    end else if (burst_reg == BW'(1)) begin
                        // The final read word is still on dma_rddata when the buffer held nothing else.
                        state_next      = ST_WR;
                        dma_rnw_next    = 1'b0;
                        dma_addr_next   = dst_reg;
                        dma_wrdata_next = fifo_empty ? dma_rddata : fifo_head;
                        burst_next      = burst_of(rem_reg);
                    end else begin
                        burst_next    = burst_reg - BW'(1);
                        dma_addr_next = src_reg + ADDR_W'(1);
                    end
                end else if (abort) begin
                    abort_pend_next = 1'b1;
                end
            end
            ST_WR: begin
                if (dma_ack) begin
                    fifo_pop = !fill_mode_reg;
                    dst_next = dst_reg + ADDR_W'(1);
                    rem_next = rem_reg - LEN_W'(1);
                    if (abort || abort_pend_reg) begin
                        stop = 1'b1;
                    end else if (last_wr && rem_reg == LEN_W'(1)) begin
                        state_next   = ST_FIN;
                        dma_req_next = 1'b0;
                        busy_next    = 1'b0;
                        done_next    = 1'b1;
                        irq_n_next   = 1'b0;
                    end else if (last_wr) begin
                        state_next    = ST_RD;
                        dma_rnw_next  = 1'b1;
                        dma_addr_next = src_reg;
                        burst_next    = burst_of(rem_reg - LEN_W'(1));
                    end else begin
                        burst_next      = burst_reg - BW'(1);
                        dma_addr_next   = dst_reg + ADDR_W'(1);
                        dma_wrdata_next = fill_mode_reg ? fill_word_reg : fifo_head_next;
                    end
                end else if (abort) begin
                    abort_pend_next = 1'b1;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Aborted transfers retire only once the outstanding access has been acked.
        if (stop) begin
            state_next      = ST_IDLE;
            dma_req_next    = 1'b0;
            busy_next       = 1'b0;
            abort_pend_next = 1'b0;
            fifo_flush      = 1'b1;
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign irq_n      = irq_n_reg;
    assign dma_req    = dma_req_reg;
    assign dma_rnw    = dma_rnw_reg;
    assign dma_addr   = dma_addr_reg;
    assign dma_wrdata = dma_wrdata_reg;
    assign dma_bsel   = DMA_BSEL_WORD;

endmodule
